mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Round-robin arbiter and sequencer that shares one SIZE-bit memory port among four requesters (fetch, load/store, DMA, debug). It selects a winner, steers that requester's address/write-data onto the shared port through 4:1 muxes driven by its `sel` output, and holds the grant until memory acknowledges or a timeout expires. It returns read data and a one-cycle ack or error pulse to the winning requester.

## Interface
- `SIZE`, 16, address and data width
- `MAX_WAIT`, 15, maximum cycles `mem_req` stays high without `mem_ack` before an error; legal range 1..255
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: reset, asynchronous, active-low
- `req` in 4: request per requester; held high until that requester sees `ack` or `err`
- `req_we` in 4: write enable per requester, valid while `req` is high
- `req_addr0`..`req_addr3` in SIZE each: per-requester address
- `req_wdata0`..`req_wdata3` in SIZE each: per-requester write data
- `grant` out 4: one-hot grant, all zeros when idle
- `sel` out 2: index of the current or last winner; drives the external 4:1 muxes
- `ack` out 4: one-cycle pulse to the winner on completion
- `err` out 4: one-cycle pulse to the winner on timeout
- `rdata` out SIZE: captured `mem_rdata`, valid in the ack cycle and held until the next ack
- `mem_req` out 1: memory access active
- `mem_we` out 1: `req_we[sel]` while `mem_req` is high, else 0
- `mem_addr`, `mem_wdata` out SIZE: requester `sel` address and write data
- `mem_ack` in 1: memory completion, sampled only while `mem_req` is high
- `mem_rdata` in SIZE: read data, valid when `mem_ack` is high

## Operation
- **Reset values:** state IDLE, `grant`=0, `sel`=0, `ack`=0, `err`=0, `rdata`=0, `mem_req`=0, wait counter=0, `last`=3 (so requester 0 has first priority).
- **FSM states:** IDLE, BUSY.
- **IDLE:**
  - If `req` is nonzero, the winner is the first set bit scanning `last+1`, `last+2`, ... (mod 4).
  - Register `sel`=winner and `grant`=one-hot(winner), clear the counter, go to BUSY.
  - If `req` is zero, stay in IDLE.
- **BUSY:** `mem_req`=1 and the port is steered by `sel`.
  - If `mem_ack`=1: register `ack[sel]`=1 and `rdata`=`mem_rdata`, set `last`=`sel`, clear `grant`, go to IDLE.
  - Else if counter==`MAX_WAIT`-1: register `err[sel]`=1, set `last`=`sel`, clear `grant`, go to IDLE.
  - Otherwise increment the counter.
- **Simultaneous `mem_ack` and timeout:** ack wins, and `err` stays 0.
- **`req[sel]` dropped in BUSY:** this is a protocol violation. It is ignored and the transaction completes normally.
- **New requests in BUSY:** they wait, with no preemption.
- **`sel` after completion:** holds its value through IDLE until the next grant.
- **Fairness:** a requester that keeps `req` asserted is served at most once every four grants when all four requesters are active.
- **Reset mid-transaction:** all outputs go to their reset values immediately and asynchronously. No ack or err is issued for the aborted access.
- **Ack/err exclusivity:** `ack` and `err` are never both nonzero, and each has at most one bit set.

## Timing
- All outputs are registered except `mem_we`, `mem_addr` and `mem_wdata`. These are combinational from `sel` and the requester inputs.
- `req` sampled at edge N (IDLE) -> `grant` and `mem_req` high after edge N.
- `mem_ack` sampled at edge K -> `ack`/`rdata` valid and `mem_req` low after edge K, for exactly one cycle.
- Minimum gap between grants is one IDLE cycle. Back-to-back zero-wait accesses give one grant every 2 cycles.
- Timeout: `mem_req` is high for exactly `MAX_WAIT` cycles, then `err` pulses in the following cycle.
- Counter width is 8 bits. It never wraps, because it is cleared on BUSY entry and capped by the timeout.

## Structure
- **Shared package:**
  - State encoding (IDLE=0, BUSY=1).
  - `NUM_REQ`=4.
  - `SEL_W`=2.
- **Sub-module `rr_priority4`:** combinational round-robin pick with inputs `req[3:0]`, `last[1:0]` and outputs `winner[1:0]`, `any`.
- **Data steering:** two instances of the existing `FourOneMux` with `size`=SIZE (address and write data), both driven by `sel`. `mem_we` is `req_we[sel]` gated by `mem_req`.

## Test plan
- **Reset then single request:** reset, then `req`=0001, write, addr 0x1234, wdata 0xBEEF; `mem_ack` on the 3rd BUSY cycle -> `grant`=0001, `mem_addr`=0x1234, `mem_we`=1, then `ack`=0001 for one cycle, `grant`=0000.
- **All requesters contending:** `req`=1111 held with zero-wait acks -> grant order 0,1,2,3,0, one grant per 2 cycles.
- **Timeout:** `MAX_WAIT`=4, `req`=0100, `mem_ack` never asserted -> `mem_req` high 4 cycles, `err`=0100 one cycle, `ack`=0, next winner scan starts at requester 3.
- **Ack on the timeout cycle:** `mem_ack` asserted in the 4th BUSY cycle with `MAX_WAIT`=4 -> `ack` pulses, `err` stays 0.
- **Read capture:** requester 3 read with `mem_rdata`=0xA5A5 at ack -> `rdata`=0xA5A5 in the ack cycle and held after `mem_rdata` changes.
- **Reset mid-access:** `rst_n` low during BUSY -> `mem_req`, `grant`, `ack`, `err` drop immediately; after release the first grant goes to the lowest active index from 0.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter.
// Holds the FSM state encoding, requester count, select and counter widths,
// and a helper that turns a requester index into a one-hot vector.
package mem_port_arbiter_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;
  localparam int CNT_W   = 8;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/FourOneMux.sv
// Generic 4:1 multiplexer used to steer requester buses onto the memory port.
// Ports: in0_i..in3_i data inputs, sel_i index, out_o selected data.
module FourOneMux #(
  parameter int size = 16
) (
  input  logic [size-1:0] in0_i,
  input  logic [size-1:0] in1_i,
  input  logic [size-1:0] in2_i,
  input  logic [size-1:0] in3_i,
  input  logic [1:0]      sel_i,
  output logic [size-1:0] out_o
);

  always_comb begin
    case (sel_i)
      2'd0:    out_o = in0_i;
      2'd1:    out_o = in1_i;
      2'd2:    out_o = in2_i;
      default: out_o = in3_i;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter_rr_priority4.sv
// Combinational round-robin pick among four requesters.
// Ports: req_i request vector, last_i previous winner,
//        winner_o first set request scanning last_i+1, last_i+2, ... (mod 4),
//        any_o high when any request is set.
module rr_priority4
  import mem_port_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [SEL_W-1:0]   last_i,
  output logic [SEL_W-1:0]   winner_o,
  output logic               any_o
);

  logic [SEL_W-1:0] idx;
  logic             found;

  always_comb begin
    winner_o = '0;
    idx      = '0;
    found    = 1'b0;
    // The index wraps naturally in SEL_W bits; k=4 lands back on last_i,
    // so the previous winner is checked last.
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = last_i + SEL_W'(k);
      if (!found && req_i[idx]) begin
        winner_o = idx;
        found    = 1'b1;
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter/sequencer sharing one memory port among four requesters
// (fetch, load/store, DMA, debug).
//
//   state | meaning
//   IDLE  | no access in flight; pick a winner when any req is set
//   BUSY  | mem_req high, port steered by sel; wait for mem_ack or timeout
//
// Ports: clk_i, rst_n_i (async, active-low); req_i/req_we_i and per-requester
// address/write data in; grant_o, sel_o, ack_o, err_o, rdata_o back to the
// requesters; mem_req_o/mem_we_o/mem_addr_o/mem_wdata_o to memory with
// mem_ack_i/mem_rdata_i returning.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int SIZE     = 16,
  parameter int MAX_WAIT = 15
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [NUM_REQ-1:0] req_we_i,
  input  logic [SIZE-1:0]    req_addr0_i,
  input  logic [SIZE-1:0]    req_addr1_i,
  input  logic [SIZE-1:0]    req_addr2_i,
  input  logic [SIZE-1:0]    req_addr3_i,
  input  logic [SIZE-1:0]    req_wdata0_i,
  input  logic [SIZE-1:0]    req_wdata1_i,
  input  logic [SIZE-1:0]    req_wdata2_i,
  input  logic [SIZE-1:0]    req_wdata3_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [SEL_W-1:0]   sel_o,
  output logic [NUM_REQ-1:0] ack_o,
  output logic [NUM_REQ-1:0] err_o,
  output logic [SIZE-1:0]    rdata_o,
  output logic               mem_req_o,
  output logic               mem_we_o,
  output logic [SIZE-1:0]    mem_addr_o,
  output logic [SIZE-1:0]    mem_wdata_o,
  input  logic               mem_ack_i,
  input  logic [SIZE-1:0]    mem_rdata_i
);

  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MAX_WAIT - 1);

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [SEL_W-1:0]   last_q, last_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic [NUM_REQ-1:0] err_q, err_d;
  logic [SIZE-1:0]    rdata_q, rdata_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [SEL_W-1:0]   winner;
  logic               any_req;

  rr_priority4 u_pick (
    .req_i    (req_i),
    .last_i   (last_q),
    .winner_o (winner),
    .any_o    (any_req)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      sel_q   <= '0;
      last_q  <= SEL_W'(NUM_REQ - 1);
      grant_q <= '0;
      ack_q   <= '0;
      err_q   <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    grant_d = grant_q;
    ack_d   = '0;
    err_d   = '0;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          sel_d   = winner;
          grant_d = onehot(winner);
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        // Ack is checked first so a completion on the timeout cycle wins.
        if (mem_ack_i) begin
          ack_d   = onehot(sel_q);
          rdata_d = mem_rdata_i;
          last_d  = sel_q;
          grant_d = '0;
          state_d = IDLE;
        end else if (cnt_q == WAIT_LAST) begin
          err_d   = onehot(sel_q);
          last_d  = sel_q;
          grant_d = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  FourOneMux #(.size(SIZE)) u_addr_mux (
    .in0_i (req_addr0_i),
    .in1_i (req_addr1_i),
    .in2_i (req_addr2_i),
    .in3_i (req_addr3_i),
    .sel_i (sel_q),
    .out_o (mem_addr_o)
  );

  FourOneMux #(.size(SIZE)) u_wdata_mux (
    .in0_i (req_wdata0_i),
    .in1_i (req_wdata1_i),
    .in2_i (req_wdata2_i),
    .in3_i (req_wdata3_i),
    .sel_i (sel_q),
    .out_o (mem_wdata_o)
  );

  assign mem_req_o = (state_q == BUSY);
  assign mem_we_o  = mem_req_o & req_we_i[sel_q];
  assign grant_o   = grant_q;
  assign sel_o     = sel_q;
  assign ack_o     = ack_q;
  assign err_o     = err_q;
  assign rdata_o   = rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int SIZE     = 16;
  localparam int MAX_WAIT = 4;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [3:0]  req_we;
  logic [15:0] a [4];
  logic [15:0] w [4];
  logic [3:0]  grant;
  logic [1:0]  sel;
  logic [3:0]  ack;
  logic [3:0]  err;
  logic [15:0] rdata;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ack;
  logic [15:0] mem_rdata;

  int n_vec = 0;
  int n_mis = 0;

  // Behavioural model: who owns the port, how many BUSY cycles have elapsed,
  // and who was served last.
  bit          m_busy;
  int          m_owner;
  int          m_last;
  int          m_age;
  bit          m_ack;
  bit          m_err;
  logic [15:0] m_rdata;

  mem_port_arbiter #(.SIZE(SIZE), .MAX_WAIT(MAX_WAIT)) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .req_i        (req),
    .req_we_i     (req_we),
    .req_addr0_i  (a[0]),
    .req_addr1_i  (a[1]),
    .req_addr2_i  (a[2]),
    .req_addr3_i  (a[3]),
    .req_wdata0_i (w[0]),
    .req_wdata1_i (w[1]),
    .req_wdata2_i (w[2]),
    .req_wdata3_i (w[3]),
    .grant_o      (grant),
    .sel_o        (sel),
    .ack_o        (ack),
    .err_o        (err),
    .rdata_o      (rdata),
    .mem_req_o    (mem_req),
    .mem_we_o     (mem_we),
    .mem_addr_o   (mem_addr),
    .mem_wdata_o  (mem_wdata),
    .mem_ack_i    (mem_ack),
    .mem_rdata_i  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_busy  = 1'b0;
    m_owner = 0;
    m_last  = 3;
    m_age   = 0;
    m_ack   = 1'b0;
    m_err   = 1'b0;
    m_rdata = '0;
  endtask

  // One clock edge's worth of the arbitration rules, using the inputs that
  // the DUT is about to sample.
  task automatic model_step();
    bit found;
    m_ack = 1'b0;
    m_err = 1'b0;
    if (!m_busy) begin
      if (req != 4'b0) begin
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
          int idx;
          idx = (m_last + k) % 4;
          if (!found && req[idx]) begin
            m_owner = idx;
            found   = 1'b1;
          end
        end
        m_busy = 1'b1;
        m_age  = 0;
      end
    end else begin
      m_age++;
      if (mem_ack) begin
        m_ack   = 1'b1;
        m_rdata = mem_rdata;
        m_last  = m_owner;
        m_busy  = 1'b0;
      end else if (m_age == MAX_WAIT) begin
        m_err  = 1'b1;
        m_last = m_owner;
        m_busy = 1'b0;
      end
    end
  endtask

  task automatic check_all();
    logic [3:0] oh;
    oh = 4'b0001 << m_owner;
    chk("grant",     32'(grant),     32'(m_busy ? oh : 4'b0));
    chk("sel",       32'(sel),       32'(m_owner));
    chk("ack",       32'(ack),       32'(m_ack ? oh : 4'b0));
    chk("err",       32'(err),       32'(m_err ? oh : 4'b0));
    chk("rdata",     32'(rdata),     32'(m_rdata));
    chk("mem_req",   32'(mem_req),   32'(m_busy));
    chk("mem_we",    32'(mem_we),    32'(m_busy && req_we[m_owner]));
    chk("mem_addr",  32'(mem_addr),  32'(a[m_owner]));
    chk("mem_wdata", 32'(mem_wdata), 32'(w[m_owner]));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req       = '0;
    req_we    = '0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    for (int i = 0; i < 4; i++) begin
      a[i] = 16'(16'h1000 * i + 16'h0010);
      w[i] = 16'(16'h0100 * i + 16'h0003);
    end
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] order [5];
    int         hi_cnt;

    order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b0100;
    order[3] = 4'b1000; order[4] = 4'b0001;

    // Reset values
    do_reset();
    chk("rst_grant",   32'(grant),   32'h0);
    chk("rst_sel",     32'(sel),     32'h0);
    chk("rst_ack",     32'(ack),     32'h0);
    chk("rst_err",     32'(err),     32'h0);
    chk("rst_rdata",   32'(rdata),   32'h0);
    chk("rst_mem_req", 32'(mem_req), 32'h0);

    // Single write from requester 0, ack in the 3rd BUSY cycle
    req = 4'b0001; req_we = 4'b0001; a[0] = 16'h1234; w[0] = 16'hBEEF;
    tick();
    chk("t1_grant",    32'(grant),     32'h1);
    chk("t1_mem_addr", 32'(mem_addr),  32'h1234);
    chk("t1_mem_wd",   32'(mem_wdata), 32'hBEEF);
    chk("t1_mem_we",   32'(mem_we),    32'h1);
    tick();
    tick();
    chk("t1_no_ack_yet", 32'(ack), 32'h0);
    mem_ack = 1'b1;
    tick();
    chk("t1_ack",   32'(ack),     32'h1);
    chk("t1_gdrop", 32'(grant),   32'h0);
    chk("t1_mreq",  32'(mem_req), 32'h0);
    req = 4'b0000; mem_ack = 1'b0;
    tick();
    chk("t1_ack_one_cycle", 32'(ack), 32'h0);

    // All four contending with zero-wait acks
    do_reset();
    req = 4'b1111; mem_ack = 1'b1;
    for (int g = 0; g < 5; g++) begin
      tick();
      chk("rr_grant", 32'(grant), 32'(order[g]));
      tick();
      chk("rr_ack",   32'(ack),   32'(order[g]));
      chk("rr_idle",  32'(grant), 32'h0);
    end

    // Timeout on requester 2
    do_reset();
    req = 4'b0100; mem_ack = 1'b0;
    hi_cnt = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (mem_req) hi_cnt++;
      if (c < 4) chk("to_no_err", 32'(err), 32'h0);
    end
    chk("to_mreq_cycles", 32'(hi_cnt),  32'd4);
    chk("to_err",         32'(err),     32'h4);
    chk("to_ack",         32'(ack),     32'h0);
    chk("to_mreq_low",    32'(mem_req), 32'h0);
    req = 4'b1011;
    tick();
    chk("to_next_winner", 32'(grant), 32'h8);

    // Ack on the timeout cycle
    do_reset();
    req = 4'b0001;
    tick();
    tick();
    tick();
    tick();
    mem_ack = 1'b1;
    tick();
    chk("ackto_ack", 32'(ack), 32'h1);
    chk("ackto_err", 32'(err), 32'h0);
    req = 4'b0000; mem_ack = 1'b0;
    tick();

    // Read capture on requester 3
    do_reset();
    req = 4'b1000; req_we = 4'b0000; mem_ack = 1'b1; mem_rdata = 16'hA5A5;
    tick();
    chk("rd_grant", 32'(grant),  32'h8);
    chk("rd_we",    32'(mem_we), 32'h0);
    tick();
    chk("rd_ack",   32'(ack),    32'h8);
    chk("rd_data",  32'(rdata),  32'hA5A5);
    req = 4'b0000; mem_ack = 1'b0; mem_rdata = 16'h1111;
    tick();
    tick();
    chk("rd_held",  32'(rdata),  32'hA5A5);

    // Reset during an access
    do_reset();
    req = 4'b0110;
    tick();
    chk("mr_grant", 32'(grant), 32'h2);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_async_grant", 32'(grant),   32'h0);
    chk("mr_async_mreq",  32'(mem_req), 32'h0);
    chk("mr_async_ack",   32'(ack),     32'h0);
    chk("mr_async_err",   32'(err),     32'h0);
    chk("mr_async_sel",   32'(sel),     32'h0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    chk("mr_first_grant", 32'(grant), 32'h2);

    // Randomised traffic
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      mem_ack   = ($urandom_range(0, 2) == 0);
      mem_rdata = 16'($urandom);
      tick();
      for (int i = 0; i < 4; i++) begin
        if (req[i]) begin
          if ((m_ack || m_err) && m_owner == i) req[i] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          req[i]    = 1'b1;
          req_we[i] = 1'($urandom);
          a[i]      = 16'($urandom);
          w[i]      = 16'($urandom);
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
